// File: rtl/rr_encoder_16_4_if.sv
// rtl/rr_encoder_16_4_if.sv - request-vector in / encoded-index out handshake bundle
interface rr_encoder_16_4_if;
    logic        in_valid;
    logic [15:0] req;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        err_zero;

    // Producer/consumer side: drives requests and out_ready, observes results
    modport master (
        output in_valid,
        output req,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_idx,
        input  out_last,
        input  err_zero
    );

    // Encoder side
    modport slave (
        input  in_valid,
        input  req,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_idx,
        output out_last,
        output err_zero
    );
endinterface

// File: rtl/rr_encoder_16_4.sv
// rtl/rr_encoder_16_4.sv - drains a 16-bit request vector as a stream of 4-bit indices
module rr_encoder_16_4 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_encoder_16_4_if.slave     bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [15:0] mask_q, mask_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        err_zero_q, err_zero_d;

    logic [3:0]  sel_idx;
    logic        single_bit;
    logic        busy;
    logic        in_fire;
    logic        out_fire;

    assign busy     = (state_q == ST_BUSY);
    assign in_fire  = bus.in_valid && !busy;
    assign out_fire = busy && bus.out_ready;

    // Circular search upward from ptr; ptr is held at 0 in fixed-priority
    // mode, so the same search yields the lowest set bit there.
    always_comb begin
        logic [3:0] pos;
        logic       found;
        sel_idx = 4'd0;
        found   = 1'b0;
        pos     = 4'd0;
        for (int i = 0; i < 16; i++) begin
            pos = ptr_q + 4'(i);
            if (!found && mask_q[pos]) begin
                sel_idx = pos;
                found   = 1'b1;
            end
        end
    end

    // Exactly one pending bit means the current index ends the vector
    always_comb begin
        single_bit = (mask_q != 16'h0) && ((mask_q & (mask_q - 16'd1)) == 16'h0);
    end

    // Next-state: accept in IDLE, retire one bit per output handshake in BUSY
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        ptr_d      = ptr_q;
        err_zero_d = 1'b0;
        if (!busy) begin
            if (in_fire) begin
                if (bus.req != 16'h0) begin
                    mask_d  = bus.req;
                    state_d = ST_BUSY;
                end else begin
                    err_zero_d = 1'b1;
                end
            end
        end else if (out_fire) begin
            mask_d = mask_q & ~(16'h0001 << sel_idx);
            if (!FIXED_PRIO) begin
                ptr_d = sel_idx + 4'd1;
            end
            if (single_bit) begin
                state_d = ST_IDLE;
            end
        end
    end

    // State registers; ptr deliberately survives vector boundaries for fairness
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mask_q     <= 16'h0;
            ptr_q      <= 4'd0;
            err_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            ptr_q      <= ptr_d;
            err_zero_q <= err_zero_d;
        end
    end

    // Outputs come from registered state only, zeroed outside BUSY
    assign bus.in_ready  = !busy;
    assign bus.out_valid = busy;
    assign bus.out_idx   = busy ? sel_idx : 4'd0;
    assign bus.out_last  = busy && single_bit;
    assign bus.err_zero  = err_zero_q;

endmodule

// File: tb/tb_rr_encoder_16_4.sv
// tb/tb_rr_encoder_16_4.sv - directed checks of round-robin and fixed-priority encoders
module tb_rr_encoder_16_4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] req;
    logic        out_ready;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    rr_encoder_16_4_if bus0 ();
    rr_encoder_16_4_if bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.req       = req;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.req       = req;
    assign bus1.out_ready = out_ready;

    rr_encoder_16_4 #(.FIXED_PRIO(1'b0)) u_rr (.clk(clk), .rst_n(rst_n), .bus(bus0));
    rr_encoder_16_4 #(.FIXED_PRIO(1'b1)) u_fp (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct {
        logic [15:0] req;
        logic [3:0]  first_rr;
        logic [3:0]  last_rr;
        logic [3:0]  first_fp;
        logic [3:0]  last_fp;
        int          n;
    } vec_t;

    vec_t tbl [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic accept(input logic [15:0] r);
        in_valid = 1'b1;
        req      = r;
        step();
        in_valid = 1'b0;
        req      = 16'h0;
    endtask

    initial begin
        logic [3:0] f0, f1, l0, l1;
        int n0, n1, cyc;

        // ptr sequence from ptr=0: 0 -> 0 -> 5 -> 5 -> 8 -> 1 -> 1 -> 0 -> 2
        tbl[0] = '{16'h8001, 4'd0,  4'd15, 4'd0,  4'd15, 2};
        tbl[1] = '{16'h0010, 4'd4,  4'd4,  4'd4,  4'd4,  1};
        tbl[2] = '{16'h0011, 4'd0,  4'd4,  4'd0,  4'd4,  2};
        tbl[3] = '{16'h00A0, 4'd5,  4'd7,  4'd5,  4'd7,  2};
        tbl[4] = '{16'h0101, 4'd8,  4'd0,  4'd0,  4'd8,  2};
        tbl[5] = '{16'h000F, 4'd1,  4'd0,  4'd0,  4'd3,  4};
        tbl[6] = '{16'hF000, 4'd12, 4'd15, 4'd12, 4'd15, 4};
        tbl[7] = '{16'h0002, 4'd1,  4'd1,  4'd1,  4'd1,  1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        req       = 16'h0;
        out_ready = 1'b1;
        step();
        step();
        chk("reset in_ready",  {31'd0, bus0.in_ready},  32'd1);
        chk("reset out_valid", {31'd0, bus0.out_valid}, 32'd0);
        chk("reset err_zero",  {31'd0, bus0.err_zero},  32'd0);
        chk("reset out_idx",   {28'd0, bus0.out_idx},   32'd0);
        rst_n = 1'b1;

        // Zero vector: one-cycle error pulse, no output
        accept(16'h0);
        chk("zero err_zero",  {31'd0, bus0.err_zero},  32'd1);
        chk("zero in_ready",  {31'd0, bus0.in_ready},  32'd1);
        chk("zero out_valid", {31'd0, bus0.out_valid}, 32'd0);
        step();
        chk("zero err_zero drop", {31'd0, bus0.err_zero}, 32'd0);
        chk("zero out_valid2",    {31'd0, bus0.out_valid}, 32'd0);

        // Table of vectors drained with out_ready held high
        for (int v = 0; v < 8; v++) begin
            accept(tbl[v].req);
            chk($sformatf("v%0d out_valid", v), {31'd0, bus0.out_valid}, 32'd1);
            chk($sformatf("v%0d in_ready busy", v), {31'd0, bus0.in_ready}, 32'd0);
            f0 = bus0.out_idx;
            f1 = bus1.out_idx;
            l0 = 4'd0; l1 = 4'd0; n0 = 0; n1 = 0; cyc = 0;
            while ((bus0.out_valid || bus1.out_valid) && cyc < 20) begin
                if (bus0.out_valid) begin
                    n0++;
                    if (bus0.out_last) l0 = bus0.out_idx;
                end
                if (bus1.out_valid) begin
                    n1++;
                    if (bus1.out_last) l1 = bus1.out_idx;
                end
                step();
                cyc++;
            end
            chk($sformatf("v%0d rr first", v), {28'd0, f0}, {28'd0, tbl[v].first_rr});
            chk($sformatf("v%0d rr last", v),  {28'd0, l0}, {28'd0, tbl[v].last_rr});
            chk($sformatf("v%0d fp first", v), {28'd0, f1}, {28'd0, tbl[v].first_fp});
            chk($sformatf("v%0d fp last", v),  {28'd0, l1}, {28'd0, tbl[v].last_fp});
            chk($sformatf("v%0d rr count", v), n0, tbl[v].n);
            chk($sformatf("v%0d fp count", v), n1, tbl[v].n);
            chk($sformatf("v%0d in_ready after", v), {31'd0, bus0.in_ready}, 32'd1);
        end

        // Backpressure (rr ptr=2): stable index 8 during a 3-cycle stall
        out_ready = 1'b0;
        accept(16'h0300);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("stall%0d valid", s), {31'd0, bus0.out_valid}, 32'd1);
            chk($sformatf("stall%0d idx", s),   {28'd0, bus0.out_idx},   32'd8);
            chk($sformatf("stall%0d last", s),  {31'd0, bus0.out_last},  32'd0);
            step();
        end
        out_ready = 1'b1;
        chk("release idx 8",  {28'd0, bus0.out_idx},  32'd8);
        step();
        chk("release idx 9",  {28'd0, bus0.out_idx},  32'd9);
        chk("release last 9", {31'd0, bus0.out_last}, 32'd1);
        step();
        chk("release done", {31'd0, bus0.out_valid}, 32'd0);

        // Mid-operation reset: rr ptr=10, drain half of 16'hFFFF
        accept(16'hFFFF);
        for (int s = 0; s < 8; s++) step();
        chk("half drained idx", {28'd0, bus0.out_idx}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", {31'd0, bus0.out_valid}, 32'd0);
        chk("async rst out_idx",   {28'd0, bus0.out_idx},   32'd0);
        chk("async rst in_ready",  {31'd0, bus0.in_ready},  32'd1);
        step();
        step();
        rst_n = 1'b1;
        accept(16'h8002);
        chk("post rst 8002 first", {28'd0, bus0.out_idx}, 32'd1);
        step();
        chk("post rst 8002 second", {28'd0, bus0.out_idx}, 32'd15);
        step();
        accept(16'h0002);
        chk("post rst 0002 idx",  {28'd0, bus0.out_idx},  32'd1);
        chk("post rst 0002 last", {31'd0, bus0.out_last}, 32'd1);
        step();
        chk("post rst in_ready",  {31'd0, bus0.in_ready}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
